// File: rtl/sym_fir_mac.sv
// rtl/sym_fir_mac.sv - folded symmetric FIR with one shared multiplier and writable coefficients
// Define SYM_FIR_SATURATE_EN to clamp results above 2^DATA_W-1 instead of wrapping.
module sym_fir_mac #(
  parameter int DATA_W = 10,
  parameter int TAPS   = 31,
  parameter int COEF_W = 11,
  parameter int SHIFT  = 10
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_sample_valid,
  input  logic [DATA_W-1:0]                 i_sample,
  input  logic                              i_coef_we,
  input  logic [$clog2((TAPS+1)/2)-1:0]     i_coef_addr,
  input  logic [COEF_W-1:0]                 i_coef_data,
  output logic                              o_busy,
  output logic                              o_out_valid,
  output logic [DATA_W-1:0]                 o_filtered,
  output logic                              o_overrun
);

  localparam int HALF  = (TAPS - 1) / 2;
  localparam int NCOEF = HALF + 1;
  localparam int AW    = $clog2(NCOEF);
  localparam int IW    = $clog2(TAPS);
  localparam int ACC_W = DATA_W + 1 + COEF_W + $clog2(NCOEF);
  localparam logic [COEF_W-1:0] C_UNITY = COEF_W'(1) << SHIFT;

  if (COEF_W < SHIFT + 1) begin : g_bad_coef_w
    $error("sym_fir_mac: COEF_W must be at least SHIFT+1");
  end
  if ((TAPS < 3) || (TAPS % 2 == 0)) begin : g_bad_taps
    $error("sym_fir_mac: TAPS must be odd and at least 3");
  end

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_v [TAPS];
  logic [COEF_W-1:0]   r_c [NCOEF];
  logic [AW-1:0]       r_idx;
  logic [ACC_W-1:0]    r_acc;
  logic                r_busy;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_filtered;
  logic                r_overrun;

  logic                w_accept;
  logic                w_coef_wr;
  logic                w_centre;
  logic [IW-1:0]       w_lo;
  logic [IW-1:0]       w_hi;
  logic [DATA_W:0]     w_pair;
  logic [ACC_W-1:0]    w_prod;
  logic [DATA_W-1:0]   w_out;

  assign w_accept  = i_sample_valid && !r_busy;
  assign w_coef_wr = i_coef_we && !r_busy && (i_coef_addr <= AW'(HALF));
  assign w_centre  = (r_idx == AW'(HALF));
  assign w_lo      = IW'(r_idx);
  assign w_hi      = IW'(TAPS - 1) - w_lo;
  // Pairing the mirrored taps halves the multiplies; the centre tap stands alone.
  assign w_pair    = w_centre ? {1'b0, r_v[w_lo]}
                              : ({1'b0, r_v[w_lo]} + {1'b0, r_v[w_hi]});
  assign w_prod    = ACC_W'(r_c[r_idx]) * ACC_W'(w_pair);

`ifdef SYM_FIR_SATURATE_EN
  logic [ACC_W-1:0] w_res;
  assign w_res = r_acc >> SHIFT;
  assign w_out = (w_res > ACC_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : w_res[DATA_W-1:0];
`else
  assign w_out = DATA_W'(r_acc >> SHIFT);
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_acc       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_filtered  <= '0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < TAPS; i++) r_v[i] <= '0;
      for (int k = 0; k < NCOEF; k++) r_c[k] <= (k == HALF) ? C_UNITY : '0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_coef_wr) r_c[i_coef_addr] <= i_coef_data;
      if (i_sample_valid && r_busy) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            for (int i = 0; i < TAPS - 1; i++) r_v[i] <= r_v[i+1];
            r_v[TAPS-1] <= i_sample;
            r_idx   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod;
          if (w_centre) r_state <= S_DONE;
          else          r_idx   <= r_idx + AW'(1);
        end
        S_DONE: begin
          r_filtered  <= w_out;
          r_out_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_out_valid = r_out_valid;
  assign o_filtered  = r_filtered;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_sym_fir_mac.sv
// tb/tb_sym_fir_mac.sv - scoreboard bench for sym_fir_mac using a direct-form reference model
module tb_sym_fir_mac;
  localparam int DW = 10, TAPS = 31, CW = 11, SH = 10, HALF = 15, NC = 16, AW = 4, LAT = 17;
`ifdef SYM_FIR_SATURATE_EN
  localparam int SAT_EXP = 1023;
`else
  localparam int SAT_EXP = 958;
`endif

  logic          clk = 1'b0;
  logic          reset, sample_valid, coef_we;
  logic [DW-1:0] sample;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_data;
  logic          busy, out_valid, overrun;
  logic [DW-1:0] filtered;

  sym_fir_mac #(.DATA_W(DW), .TAPS(TAPS), .COEF_W(CW), .SHIFT(SH)) dut (
    .i_clk(clk), .i_reset(reset), .i_sample_valid(sample_valid), .i_sample(sample),
    .i_coef_we(coef_we), .i_coef_addr(coef_addr), .i_coef_data(coef_data),
    .o_busy(busy), .o_out_valid(out_valid), .o_filtered(filtered), .o_overrun(overrun)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int s; int e; } vec_t;
  vec_t tbl [21];

  int checks = 0, errors = 0, cyc = 0, n_pulses = 0, p0;
  logic [DW-1:0] exp_q [$];
  int            acc_q [$];
  int            last_filt = 0;
  int            m_v [TAPS];
  int            m_c [NC];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    foreach (m_v[j]) m_v[j] = 0;
    foreach (m_c[k]) m_c[k] = 0;
    m_c[HALF] = 1 << SH;
  endtask

  function automatic int model_out();
    longint a = 0;
    for (int j = 0; j < TAPS; j++) a += longint'(m_c[(j <= HALF) ? j : TAPS-1-j]) * m_v[j];
    a = a >> SH;
`ifdef SYM_FIR_SATURATE_EN
    if (a > 1023) a = 1023;
`else
    a = a & 1023;
`endif
    return int'(a);
  endfunction

  // e < 0 means the reference model supplies the expected result
  task automatic send_raw(input int s, input int e);
    int g = 0;
    while (busy && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) begin chk("busy_timeout", int'(busy), 0); return; end
    for (int j = 0; j < TAPS-1; j++) m_v[j] = m_v[j+1];
    m_v[TAPS-1] = s;
    if (e < 0) e = model_out();
    sample = DW'(s);
    sample_valid = 1'b1;
    exp_q.push_back(DW'(e));
    @(negedge clk);
    sample_valid = 1'b0;
    acc_q.push_back(cyc);
  endtask

  task automatic write_coef(input int addr, input int data, input bit upd);
    coef_we = 1'b1; coef_addr = AW'(addr); coef_data = CW'(data);
    if (upd) m_c[addr] = data;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 300) begin @(negedge clk); g++; end
    if (g >= 300) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; sample_valid = 1'b0; coef_we = 1'b0;
    exp_q.delete(); acc_q.delete(); model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(negedge clk);
    if (reset) last_filt = 0;
    else if (out_valid) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_valid actual=1 required=0");
      end else begin
        chk("filtered", int'(filtered), int'(exp_q.pop_front()));
        chk("latency", cyc - acc_q.pop_front(), LAT);
      end
      last_filt = int'(filtered);
    end else chk("filtered_hold", int'(filtered), last_filt);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; sample_valid = 1'b0; sample = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    foreach (tbl[i]) begin tbl[i].s = 0; tbl[i].e = 0; end
    tbl[0].s  = 100;
    tbl[15].e = 100;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_filtered", int'(filtered), 0);
    chk("reset_overrun", int'(overrun), 0);

    for (int i = 0; i < 21; i++) send_raw(tbl[i].s, tbl[i].e);
    drain();
    chk("pass_pulses", n_pulses, 21);

    for (int k = 0; k < NC; k++) write_coef(k, 64, 1'b1);
    for (int i = 0; i < 30; i++) send_raw(512, -1);
    send_raw(512, 992);
    drain();
    for (int i = 0; i < 30; i++) send_raw(1023, -1);
    send_raw(1023, SAT_EXP);
    drain();

    do_reset();
    chk("overrun_clear", int'(overrun), 0);
    p0 = n_pulses;
    send_raw(300, -1);
    repeat (4) @(negedge clk);
    sample = DW'(777); sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("overrun_set", int'(overrun), 1);
    drain();
    chk("overrun_pulses", n_pulses - p0, 1);
    for (int i = 0; i < 14; i++) send_raw(0, -1);
    send_raw(0, 300);
    drain();
    chk("overrun_sticky", int'(overrun), 1);

    p0 = n_pulses;
    send_raw(500, -1);
    repeat (7) @(negedge clk);
    do_reset();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_filtered", int'(filtered), 0);
    chk("midrst_overrun", int'(overrun), 0);
    repeat (25) @(negedge clk);
    chk("midrst_pulses", n_pulses - p0, 0);
    for (int i = 0; i < 15; i++) send_raw(500, -1);
    send_raw(500, 500);
    drain();

    do_reset();
    for (int i = 0; i < 16; i++) send_raw(200, -1);
    send_raw(200, 200);
    write_coef(15, 0, 1'b0);
    drain();
    write_coef(15, 0, 1'b1);
    send_raw(200, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
